div_ctrl: RTL
=============

// Module: div_ctrl
// PURPOSE
//  Multi-cycle radix-2 restoring divider with its sequencing FSM, serving the EX stage for DIV/DIVU.
//  EX issues a start with two operands and holds start_i high; div_ctrl iterates one quotient bit per cycle.
//  It returns {remainder,quotient} with ready_o, ready for the HI/LO write path (HI=remainder, LO=quotient).
//  EX derives its pipeline stall request from start_i & ~ready_o; annul_i aborts on a pipeline flush.
// PARAMETERS
//  WIDTH  32  operand width; result is 2*WIDTH, iteration count is WIDTH
// PORTS
//  clk           in   1        clock, all state updates on rising edge
//  rst           in   1        reset, asynchronous, active-low (0 = reset)
//  signed_div_i  in   1        1 = signed (DIV), 0 = unsigned (DIVU); sampled at start
//  opdata1_i     in   WIDTH    dividend; sampled at start
//  opdata2_i     in   WIDTH    divisor; sampled at start
//  start_i       in   1        request; held high until ready_o seen
//  annul_i       in   1        abort current division (flush)
//  result_o      out  2*WIDTH  {remainder, quotient}, valid while ready_o=1
//  ready_o       out  1        result valid
//  busy_o        out  1        state != IDLE (combinational)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cnt=0, work reg=0, result_o=0, ready_o=0.
//  States: IDLE, BYZERO, ON, END. All outputs except busy_o are registered.
//  IDLE: start_i=1 & annul_i=0 & opdata2_i==0 -> BYZERO.
//        start_i=1 & annul_i=0 & opdata2_i!=0 -> ON; cnt<=0; latch signs, signed flag.
//          Signed: latch |op1|, |op2| (two's-complement negate if MSB set); |-2^(W-1)| = 2^(W-1) unsigned.
//          Work reg (2W+1 bits) <= {W'b0, |op1|, 1'b0}; divisor reg <= |op2|.
//        otherwise stay; result_o=0, ready_o=0.
//  BYZERO: next edge -> END, result_o<=0, ready_o<=1.
//  ON, annul_i=0, cnt<W: diff = {1'b0,work[2W-1:W]} - {1'b0,divisor} (W+1 bits).
//        diff[W]=1 (negative): work <= {work[2W-1:0],1'b0}.
//        else: work <= {diff[W-1:0], work[W-1:0], 1'b1}.  cnt<=cnt+1.
//  ON, annul_i=0, cnt==W: -> END; q=work[W-1:0], r=work[2W:W+1];
//        signed & (op1 sign ^ op2 sign): q negated; signed & op1 negative: r negated.
//        result_o<={r,q}; ready_o<=1.  (-2^(W-1) / -1 signed -> q=2^(W-1) pattern, r=0; no trap.)
//  ON, annul_i=1: -> IDLE next edge, ready_o=0, result_o=0; partial result discarded.
//  END: start_i=1 & annul_i=0 -> hold END, result_o/ready_o stable.
//        start_i=0 or annul_i=1 -> IDLE, ready_o<=0, result_o<=0.
//  BYZERO, annul_i=1: -> IDLE (annul overrides).
//  IDLE, start_i=1 & annul_i=1: start ignored, stay IDLE.
//  Latency: start sampled at edge t0 -> ready_o=1 after edge t0+W+2 (W=32: 34 cycles);
//        divide-by-zero -> ready_o=1 after edge t0+2.
//  Operand/sign/start-polarity changes while ON are ignored (values latched at start).
//  A new division needs at least one cycle with start_i=0 (END->IDLE) before next start.
//  Reset asserted mid-operation: immediate return to reset values; no partial result escapes.
// TESTING
//  1 unsigned 100/7, start held -> ready_o rises 34 cycles after start; result_o={32'd2,32'd14}.
//  2 signed -7/2 (FFFFFFF9/00000002) -> result_o={FFFFFFFF,FFFFFFFD}; 7/-2 -> {00000001,FFFFFFFD}.
//  3 divisor 0, any dividend -> ready_o=1 two cycles after start, result_o=64'h0; start_i low -> ready_o=0 next cycle.
//  4 start 100/7, annul_i=1 on ON cycle 10 -> IDLE next edge, ready_o never 1; new start 9/3 -> {0,3} after 34.
//  5 unsigned FFFFFFFF/1 -> {0,FFFFFFFF}; signed 80000000/FFFFFFFF -> {0,80000000}.
//  6 rst low at ON cycle 20 -> ready_o=0, result_o=0, busy_o=0 immediately; after release, 50/5 -> {0,10}.

Source files
------------

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Returns {remainder, quotient} with ready_o, held while start_i stays high.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   work;
    logic [WIDTH-1:0]   divisor;
    logic               op1_neg;
    logic               op2_neg;
    logic               sign_flag;

    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   q_raw;
    logic [WIDTH-1:0]   r_raw;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Magnitudes only matter for signed operands; -2^(W-1) negates to itself, which is the right unsigned value
    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    assign diff  = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    assign q_raw = work[WIDTH-1:0];
    assign r_raw = work[2*WIDTH:WIDTH+1];
    assign q_fix = (sign_flag && (op1_neg ^ op2_neg)) ? (~q_raw + 1'b1) : q_raw;
    assign r_fix = (sign_flag && op1_neg) ? (~r_raw + 1'b1) : r_raw;

    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            work      <= '0;
            divisor   <= '0;
            op1_neg   <= 1'b0;
            op2_neg   <= 1'b0;
            sign_flag <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end else begin
                            state     <= S_ON;
                            cnt       <= '0;
                            sign_flag <= signed_div_i;
                            op1_neg   <= signed_div_i & opdata1_i[WIDTH-1];
                            op2_neg   <= signed_div_i & opdata2_i[WIDTH-1];
                            work      <= {{WIDTH{1'b0}}, op1_abs, 1'b0};
                            divisor   <= op2_abs;
                        end
                    end
                end
                S_BYZERO: begin
                    result_o <= '0;
                    if (annul_i) begin
                        state   <= S_IDLE;
                        ready_o <= 1'b0;
                    end else begin
                        state   <= S_END;
                        ready_o <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state    <= S_IDLE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        // Restoring step: subtract only when the partial remainder covers the divisor
                        if (diff[WIDTH]) begin
                            work <= {work[2*WIDTH-1:0], 1'b0};
                        end else begin
                            work <= {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
                        end
                        cnt <= cnt + 1'b1;
                    end else begin
                        state    <= S_END;
                        result_o <= {r_fix, q_fix};
                        ready_o  <= 1'b1;
                    end
                end
                S_END: begin
                    if (!start_i || annul_i) begin
                        state    <= S_IDLE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
